// File: rtl/ewb_queue_pkg.sv
// Shared types and default widths for the eviction write buffer.
package ewb_queue_pkg;

  localparam int EWB_ADDR_W = 16;
  localparam int EWB_LINE_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_DRAIN = 2'd2,
    S_READ  = 2'd3
  } ewb_state_t;

endpackage

// File: rtl/ewb_match.sv
// Parallel address compare of the cpu line address against every valid
// buffer entry. The head entry can be masked out while it is being drained,
// so a write to an in-flight line is never coalesced into it.
module ewb_match
  import ewb_queue_pkg::*;
#(
  parameter int ADDR_W = EWB_ADDR_W,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]            i_adr,
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_entry_adr,
  input  logic                         i_excl_head,
  input  logic [IDX_W-1:0]             i_head,
  output logic                         o_hit,
  output logic [DEPTH-1:0]             o_onehot,
  output logic [IDX_W-1:0]             o_idx
);

  // Per-entry compare; coalescing keeps at most one bit set, so OR-ing the
  // indices of set bits yields the matching index directly.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_onehot[i] = i_valid[i] && (i_entry_adr[i] == i_adr) &&
                    !(i_excl_head && (i_head == IDX_W'(i)));
      o_idx       = o_idx | (o_onehot[i] ? IDX_W'(i) : '0);
    end
    o_hit = |o_onehot;
  end

endmodule

// File: rtl/ewb_queue.sv
// Eviction write buffer between L1 and memory: a circular FIFO of dirty
// lines with write coalescing, read-hit service and read-miss pass-through.
// Drains happen when the cpu has been idle long enough or a write finds the
// buffer full.
module ewb_queue
  import ewb_queue_pkg::*;
#(
  parameter int ADDR_W      = EWB_ADDR_W,
  parameter int LINE_W      = EWB_LINE_W,
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_cyc,
  input  logic                     cpu_stb,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_adr,
  input  logic [LINE_W-1:0]        cpu_wdata,
  output logic [LINE_W-1:0]        cpu_rdata,
  output logic                     cpu_ack,
  output logic                     mem_cyc,
  output logic                     mem_stb,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_adr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IC_W  = $clog2(IDLE_CYCLES + 1);

  ewb_state_t                  r_state;
  ewb_state_t                  w_state_nxt;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_adr;
  logic [DEPTH-1:0][LINE_W-1:0] r_data;
  logic [PTR_W-1:0]            r_head;
  logic [PTR_W-1:0]            r_tail;
  logic [CNT_W-1:0]            r_count;
  logic [IC_W-1:0]             r_idle_cnt;
  logic [LINE_W-1:0]           r_rdata;

  logic                        w_req;
  logic                        w_hit;
  logic [DEPTH-1:0]            w_onehot;
  logic [PTR_W-1:0]            w_idx;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_coal;
  logic                        w_rd_hit;

  assign w_req = cpu_cyc & cpu_stb;

  ewb_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (PTR_W)
  ) u_match (
    .i_adr       (cpu_adr),
    .i_valid     (r_valid),
    .i_entry_adr (r_adr),
    .i_excl_head (r_state == S_DRAIN),
    .i_head      (r_head),
    .o_hit       (w_hit),
    .o_onehot    (w_onehot),
    .o_idx       (w_idx)
  );

  // Next-state and FIFO action decode; S_IDLE resolves requests in priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_coal      = 1'b0;
    w_rd_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && cpu_we) begin
          if (w_hit) begin
            w_coal      = 1'b1;
            w_state_nxt = S_ACK;
          end else if (r_count != CNT_W'(DEPTH)) begin
            w_push      = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (w_req) begin
          if (w_hit) begin
            w_rd_hit    = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_READ;
          end
        end else if ((r_count != '0) && (r_idle_cnt >= IC_W'(IDLE_CYCLES))) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and cpu-idle counter (saturating, cleared by any request).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req) begin
        r_idle_cnt <= '0;
      end else if ((r_state == S_IDLE) && (r_idle_cnt < IC_W'(IDLE_CYCLES))) begin
        r_idle_cnt <= r_idle_cnt + IC_W'(1);
      end else begin
        r_idle_cnt <= r_idle_cnt;
      end
    end
  end

  // Entry storage, pointers and count; push, coalesce and pop are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_adr   <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_tail == PTR_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_adr[i]   <= cpu_adr;
          r_data[i]  <= cpu_wdata;
        end else if (w_coal && w_onehot[i]) begin
          r_data[i]  <= cpu_wdata;
        end else if (w_pop && (r_head == PTR_W'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_tail  <= r_tail + PTR_W'(1);
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_head  <= r_head + PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
      if (w_rd_hit) begin
        r_rdata <= r_data[w_idx];
      end
    end
  end

  // Bus outputs decoded from the state register; read misses pass memory straight through.
  always_comb begin
    mem_cyc   = (r_state == S_DRAIN) || (r_state == S_READ);
    mem_stb   = mem_cyc;
    mem_we    = (r_state == S_DRAIN);
    mem_adr   = '0;
    mem_wdata = '0;
    cpu_ack   = (r_state == S_ACK);
    cpu_rdata = r_rdata;
    if (r_state == S_DRAIN) begin
      mem_adr   = r_adr[r_head];
      mem_wdata = r_data[r_head];
    end else if (r_state == S_READ) begin
      mem_adr   = cpu_adr;
      cpu_ack   = mem_ack;
      cpu_rdata = mem_rdata;
    end else begin
      mem_adr   = '0;
    end
    count = r_count;
  end

endmodule

// File: tb/tb_ewb_queue.sv
// Directed bench for ewb_queue with a scoreboard of expected drains and reads.
module tb_ewb_queue;

  localparam int AW = 16;
  localparam int LW = 128;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [LW-1:0] data;
  } drain_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_cyc, cpu_stb, cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [LW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          mem_cyc, mem_stb, mem_we;
  logic [AW-1:0] mem_adr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [2:0]    count;

  drain_t        exp_drain[$];
  logic [LW-1:0] exp_rd[$];
  int            checks = 0;
  int            errors = 0;
  int            drains_done = 0;
  int            n_mem_cyc = 0;
  int            mem_lat = 3;
  int            busy = 0;

  ewb_queue #(.ADDR_W(AW), .LINE_W(LW), .DEPTH(4), .IDLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{a}};
  endfunction

  function automatic logic [LW-1:0] dat(input logic [7:0] k);
    return {4{24'hC0DE00, k}};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_drain(input logic [AW-1:0] a, input logic [LW-1:0] d);
    drain_t e;
    e.adr  = a;
    e.data = d;
    exp_drain.push_back(e);
  endtask

  task automatic cpu_req(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] d);
    cpu_cyc   = 1'b1;
    cpu_stb   = 1'b1;
    cpu_we    = we;
    cpu_adr   = a;
    cpu_wdata = d;
  endtask

  task automatic cpu_end();
    cpu_cyc = 1'b0;
    cpu_stb = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int max, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < max);
    chk(tag, LW'(cpu_ack), LW'(1'b1));
  endtask

  task automatic cpu_write(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] d,
                           output int lat);
    cpu_req(1'b1, a, d);
    wait_ack(tag, 40, lat);
    cpu_end();
  endtask

  task automatic wait_count(input logic [2:0] target, input int max);
    int n = 0;
    while (count != target && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Memory model: acks after mem_lat cycles, scores drains, returns patterned read data.
  initial begin
    drain_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_cyc) n_mem_cyc++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_cyc && mem_stb) begin
        busy++;
        if (busy >= mem_lat) begin
          busy    = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            drains_done++;
            chk("drain_expected", LW'(exp_drain.size() > 0), LW'(1'b1));
            if (exp_drain.size() > 0) begin
              e = exp_drain.pop_front();
              chk("drain_adr", LW'(mem_adr), LW'(e.adr));
              chk("drain_data", mem_wdata, e.data);
            end
          end else begin
            mem_rdata = pat(mem_adr);
          end
        end
      end else begin
        busy = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int base;
    int k;
    int n;
    rst_n = 1'b0;
    cpu_end();
    cpu_adr   = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", LW'(count), LW'(3'd0));
    chk("rst_cpu_ack", LW'(cpu_ack), LW'(1'b0));
    chk("rst_mem_cyc", LW'(mem_cyc), LW'(1'b0));
    chk("rst_mem_stb", LW'(mem_stb), LW'(1'b0));
    chk("rst_mem_we", LW'(mem_we), LW'(1'b0));
    chk("rst_mem_adr", LW'(mem_adr), LW'(16'h0000));
    chk("rst_mem_wdata", mem_wdata, LW'(1'b0));
    chk("rst_cpu_rdata", cpu_rdata, LW'(1'b0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("empty_no_drain", LW'(mem_cyc), LW'(1'b0));

    // Buffered write, coalesce, read hit with no memory traffic.
    base = n_mem_cyc;
    cpu_write("wr_d1_ack", 16'h0010, dat(8'hD1), lat);
    chk("wr_latency", LW'(lat), LW'(1));
    chk("count_after_wr", LW'(count), LW'(3'd1));
    cpu_write("coal_ack", 16'h0010, dat(8'hD2), lat);
    chk("count_after_coal", LW'(count), LW'(3'd1));
    exp_rd.push_back(dat(8'hD2));
    cpu_req(1'b0, 16'h0010, '0);
    wait_ack("rd_hit_ack", 40, lat);
    chk("rd_hit_data", cpu_rdata, exp_rd.pop_front());
    cpu_end();
    chk("hit_no_mem", LW'(n_mem_cyc), LW'(base));

    // Opportunistic drain after two idle cycles.
    push_drain(16'h0010, dat(8'hD2));
    repeat (3) @(negedge clk);
    chk("no_early_drain", LW'(mem_cyc), LW'(1'b0));
    @(negedge clk);
    chk("idle_drain_cyc", LW'(mem_cyc), LW'(1'b1));
    chk("idle_drain_we", LW'(mem_we), LW'(1'b1));
    chk("idle_drain_adr", LW'(mem_adr), LW'(16'h0010));
    wait_count(3'd0, 30);
    chk("count_after_drain", LW'(count), LW'(3'd0));

    // Fill, then a fifth write stalls until the head drains.
    for (int i = 1; i <= 4; i++) begin
      push_drain(AW'(16 * i), dat(8'(i)));
      cpu_write("fill_ack", AW'(16 * i), dat(8'(i)), lat);
    end
    chk("count_full", LW'(count), LW'(3'd4));
    k = drains_done;
    cpu_write("wr5_ack", 16'h0050, dat(8'h05), lat);
    push_drain(16'h0050, dat(8'h05));
    chk("wr5_after_drain", LW'(drains_done), LW'(k + 1));
    chk("wr5_stalled", LW'(lat >= 5), LW'(1'b1));
    chk("count_after_wr5", LW'(count), LW'(3'd4));

    // Read miss while two entries remain buffered.
    wait_count(3'd2, 60);
    chk("count_two", LW'(count), LW'(3'd2));
    exp_rd.push_back(pat(16'h0200));
    cpu_req(1'b0, 16'h0200, '0);
    @(negedge clk);
    chk("miss_mem_cyc", LW'(mem_cyc), LW'(1'b1));
    chk("miss_mem_we", LW'(mem_we), LW'(1'b0));
    chk("miss_mem_adr", LW'(mem_adr), LW'(16'h0200));
    wait_ack("miss_ack", 40, lat);
    chk("miss_ack_is_mem_ack", LW'(mem_ack), LW'(1'b1));
    chk("miss_data", cpu_rdata, exp_rd.pop_front());
    cpu_end();
    chk("count_after_miss", LW'(count), LW'(3'd2));

    // Read miss arriving while a drain is in flight.
    n = 0;
    while (!(mem_cyc && mem_we) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_flight", LW'(mem_we), LW'(1'b1));
    k = drains_done;
    exp_rd.push_back(pat(16'h0300));
    cpu_req(1'b0, 16'h0300, '0);
    wait_ack("mid_miss_ack", 40, lat);
    chk("drain_before_read", LW'(drains_done), LW'(k + 1));
    chk("mid_miss_adr", LW'(mem_adr), LW'(16'h0300));
    chk("mid_miss_data", cpu_rdata, exp_rd.pop_front());
    chk("count_after_mid", LW'(count), LW'(3'd1));
    cpu_end();
    wait_count(3'd0, 40);
    chk("all_drained", LW'(exp_drain.size()), LW'(0));

    // Reset during a drain abandons it; the line is gone afterwards.
    mem_lat = 8;
    cpu_write("wr7_ack", 16'h0700, dat(8'h07), lat);
    n = 0;
    while (!mem_cyc && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain7_started", LW'(mem_cyc), LW'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_cyc", LW'(mem_cyc), LW'(1'b0));
    chk("rst_clears_count", LW'(count), LW'(3'd0));
    @(negedge clk);
    rst_n   = 1'b1;
    mem_lat = 3;
    exp_rd.push_back(pat(16'h0700));
    cpu_req(1'b0, 16'h0700, '0);
    @(negedge clk);
    chk("post_rst_miss_cyc", LW'(mem_cyc), LW'(1'b1));
    chk("post_rst_miss_we", LW'(mem_we), LW'(1'b0));
    wait_ack("post_rst_ack", 40, lat);
    chk("post_rst_data", cpu_rdata, exp_rd.pop_front());
    cpu_end();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
